// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: instruction field positions,
// opcode/function codes, ALUC encodings and the decoded payload struct.
package id_ex_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ALUC_W = 4;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned FUNC_W = 6;
  localparam int unsigned SA_W   = 5;
  localparam int unsigned IMM_W  = 16;

  // Instruction field LSB positions
  localparam int unsigned OP_LSB   = 26;
  localparam int unsigned RS_LSB   = 21;
  localparam int unsigned RT_LSB   = 16;
  localparam int unsigned RD_LSB   = 11;
  localparam int unsigned SA_LSB   = 6;
  localparam int unsigned FUNC_LSB = 0;
  localparam int unsigned IMM_LSB  = 0;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // R-type function codes
  localparam logic [FUNC_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNC_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNC_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNC_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNC_W-1:0] FN_XOR = 6'b100110;
  localparam logic [FUNC_W-1:0] FN_SLL = 6'b000000;
  localparam logic [FUNC_W-1:0] FN_SRL = 6'b000010;
  localparam logic [FUNC_W-1:0] FN_SRA = 6'b000011;

  // ALU control encodings
  localparam logic [ALUC_W-1:0] ALUC_ADD = 4'b0000;
  localparam logic [ALUC_W-1:0] ALUC_SUB = 4'b0100;
  localparam logic [ALUC_W-1:0] ALUC_AND = 4'b0001;
  localparam logic [ALUC_W-1:0] ALUC_OR  = 4'b0101;
  localparam logic [ALUC_W-1:0] ALUC_XOR = 4'b0010;
  localparam logic [ALUC_W-1:0] ALUC_LUI = 4'b0110;
  localparam logic [ALUC_W-1:0] ALUC_SLL = 4'b0011;
  localparam logic [ALUC_W-1:0] ALUC_SRL = 4'b0111;
  localparam logic [ALUC_W-1:0] ALUC_SRA = 4'b1111;

  // Decoded instruction payload carried into the ID/EX register
  typedef struct packed {
    logic [ALUC_W-1:0] aluc;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] st_data;
    logic [REG_W-1:0]  wn;
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic              illegal;
  } dec_t;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
    return DATA_W'(imm);
  endfunction

endpackage

// File: rtl/id_ex_stage_decoder.sv
// Combinational instruction decoder.
// Ports: inst/rs_data/rt_data in; rs_addr/rt_addr (register read indices),
// dec (ALUC, operands, destination, controls), uses_rt (rt is a source) out.
module id_decoder
  import id_ex_stage_pkg::*;
(
  input  logic [DATA_W-1:0] inst,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [REG_W-1:0]  rs_addr,
  output logic [REG_W-1:0]  rt_addr,
  output dec_t              dec,
  output logic              uses_rt
);

  logic [OP_W-1:0]   op;
  logic [FUNC_W-1:0] func;
  logic [SA_W-1:0]   sa;
  logic [IMM_W-1:0]  imm;
  logic [REG_W-1:0]  rd;

  assign op      = inst[OP_LSB +: OP_W];
  assign func    = inst[FUNC_LSB +: FUNC_W];
  assign sa      = inst[SA_LSB +: SA_W];
  assign imm     = inst[IMM_LSB +: IMM_W];
  assign rd      = inst[RD_LSB +: REG_W];
  assign rs_addr = inst[RS_LSB +: REG_W];
  assign rt_addr = inst[RT_LSB +: REG_W];

  // Field decode; illegal encodings collapse to an all-zero payload
  always_comb begin
    dec     = '0;
    uses_rt = 1'b0;
    case (op)
      OP_RTYPE: begin
        uses_rt  = 1'b1;
        dec.wn   = rd;
        dec.wreg = 1'b1;
        dec.a    = rs_data;
        dec.b    = rt_data;
        case (func)
          FN_ADD: dec.aluc = ALUC_ADD;
          FN_SUB: dec.aluc = ALUC_SUB;
          FN_AND: dec.aluc = ALUC_AND;
          FN_OR:  dec.aluc = ALUC_OR;
          FN_XOR: dec.aluc = ALUC_XOR;
          FN_SLL: begin dec.aluc = ALUC_SLL; dec.a = DATA_W'(sa); end
          FN_SRL: begin dec.aluc = ALUC_SRL; dec.a = DATA_W'(sa); end
          FN_SRA: begin dec.aluc = ALUC_SRA; dec.a = DATA_W'(sa); end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: begin
        dec.wn   = rt_addr;
        dec.wreg = 1'b1;
        dec.a    = rs_data;
        case (op)
          OP_ADDI: begin dec.aluc = ALUC_ADD; dec.b = sext_imm(imm); end
          OP_ANDI: begin dec.aluc = ALUC_AND; dec.b = zext_imm(imm); end
          OP_ORI:  begin dec.aluc = ALUC_OR;  dec.b = zext_imm(imm); end
          OP_XORI: begin dec.aluc = ALUC_XOR; dec.b = zext_imm(imm); end
          OP_LUI:  begin dec.aluc = ALUC_LUI; dec.b = zext_imm(imm); end
          OP_LW: begin
            dec.aluc  = ALUC_ADD;
            dec.b     = sext_imm(imm);
            dec.m2reg = 1'b1;
          end
          default: begin  // sw
            uses_rt     = 1'b1;
            dec.aluc    = ALUC_ADD;
            dec.b       = sext_imm(imm);
            dec.wmem    = 1'b1;
            dec.wreg    = 1'b0;
            dec.st_data = rt_data;
          end
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase

    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    // Writes to $0 are architecturally discarded
    if (dec.wn == '0) dec.wreg = 1'b0;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX stage: decodes the fetched instruction, reads the register file,
// and holds the ALU operands/controls for execute behind a valid/ready
// handshake. Inserts one bubble on a load-use hazard; FLUSH drops work.
// Ports: CLK/RST; INST/IN_VALID/IN_READY (fetch side); RS_ADDR/RT_ADDR,
// RS_DATA/RT_DATA (register file); FLUSH; OUT_VALID/OUT_READY, ALUC,
// A_OPD, B_OPD, ST_DATA, WN, WREG, M2REG, WMEM, ILLEGAL (execute side).
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CTRL_WIDTH     = 4,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     INST,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  output logic [REG_ADDR_WIDTH-1:0] RS_ADDR,
  output logic [REG_ADDR_WIDTH-1:0] RT_ADDR,
  input  logic [DATA_WIDTH-1:0]     RS_DATA,
  input  logic [DATA_WIDTH-1:0]     RT_DATA,
  input  logic                      FLUSH,
  input  logic                      OUT_READY,
  output logic                      OUT_VALID,
  output logic [CTRL_WIDTH-1:0]     ALUC,
  output logic [DATA_WIDTH-1:0]     A_OPD,
  output logic [DATA_WIDTH-1:0]     B_OPD,
  output logic [DATA_WIDTH-1:0]     ST_DATA,
  output logic [REG_ADDR_WIDTH-1:0] WN,
  output logic                      WREG,
  output logic                      M2REG,
  output logic                      WMEM,
  output logic                      ILLEGAL
);

  dec_t             dec;
  dec_t             out_q;
  logic             valid_q;
  logic             uses_rt;
  logic [REG_W-1:0] rs_addr;
  logic [REG_W-1:0] rt_addr;
  logic             haz_c;

  id_decoder u_decoder (
    .inst    (INST),
    .rs_data (RS_DATA),
    .rt_data (RT_DATA),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .dec     (dec),
    .uses_rt (uses_rt)
  );

  assign RS_ADDR = rs_addr;
  assign RT_ADDR = rt_addr;

  // Load in the output register whose result the incoming instruction reads
  assign haz_c = valid_q & out_q.m2reg & (out_q.wn != '0) &
                 ((out_q.wn == rs_addr) | (uses_rt & (out_q.wn == rt_addr)));

  assign IN_READY = !FLUSH & !haz_c & (!valid_q | OUT_READY);

  // Output register; controls drop with valid so no stale write is visible
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (FLUSH) begin
      valid_q       <= 1'b0;
      out_q.wreg    <= 1'b0;
      out_q.m2reg   <= 1'b0;
      out_q.wmem    <= 1'b0;
      out_q.illegal <= 1'b0;
    end else if (IN_VALID && IN_READY) begin
      valid_q <= 1'b1;
      out_q   <= dec;
    end else if (OUT_READY) begin
      valid_q       <= 1'b0;
      out_q.wreg    <= 1'b0;
      out_q.m2reg   <= 1'b0;
      out_q.wmem    <= 1'b0;
      out_q.illegal <= 1'b0;
    end
  end

  assign OUT_VALID = valid_q;
  assign ALUC      = out_q.aluc;
  assign A_OPD     = out_q.a;
  assign B_OPD     = out_q.b;
  assign ST_DATA   = out_q.st_data;
  assign WN        = out_q.wn;
  assign WREG      = out_q.wreg;
  assign M2REG     = out_q.m2reg;
  assign WMEM      = out_q.wmem;
  assign ILLEGAL   = out_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  aluc;
  logic [31:0] a_opd;
  logic [31:0] b_opd;
  logic [31:0] st_data;
  logic [4:0]  wn;
  logic        wreg;
  logic        m2reg;
  logic        wmem;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  id_ex_stage dut (
    .CLK       (clk),
    .RST       (rst),
    .INST      (inst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .RS_ADDR   (rs_addr),
    .RT_ADDR   (rt_addr),
    .RS_DATA   (rs_data),
    .RT_DATA   (rt_data),
    .FLUSH     (flush),
    .OUT_READY (out_ready),
    .OUT_VALID (out_valid),
    .ALUC      (aluc),
    .A_OPD     (a_opd),
    .B_OPD     (b_opd),
    .ST_DATA   (st_data),
    .WN        (wn),
    .WREG      (wreg),
    .M2REG     (m2reg),
    .WMEM      (wmem),
    .ILLEGAL   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge so registered outputs are settled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    inst = 32'h00221820; rs_data = 32'd9; rt_data = 32'd9;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
    checks++; if (aluc !== 4'h0) begin errors++; $display("FAIL reset_aluc got=%0h exp=0", aluc); end
    checks++; if (a_opd !== 32'h0 || b_opd !== 32'h0 || st_data !== 32'h0) begin errors++; $display("FAIL reset_opd got=%0h/%0h/%0h exp=0", a_opd, b_opd, st_data); end
    checks++; if (wn !== 5'd0 || wreg !== 1'b0 || m2reg !== 1'b0 || wmem !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL reset_ctrl got wn=%0d wreg=%0b m2reg=%0b wmem=%0b ill=%0b exp=0", wn, wreg, m2reg, wmem, illegal); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_alu_ops();
    @(negedge clk);
    inst = 32'h00221820; rs_data = 32'd5; rt_data = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (rs_addr !== 5'd1 || rt_addr !== 5'd2) begin errors++; $display("FAIL add_raddr got=%0d/%0d exp=1/2", rs_addr, rt_addr); end
    tick();
    checks++; if (out_valid !== 1'b1 || aluc !== 4'b0000 || a_opd !== 32'd5 || b_opd !== 32'd7) begin errors++; $display("FAIL add_out got v=%0b aluc=%0h a=%0h b=%0h exp v=1 aluc=0 a=5 b=7", out_valid, aluc, a_opd, b_opd); end
    checks++; if (wn !== 5'd3 || wreg !== 1'b1 || m2reg !== 1'b0 || wmem !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL add_ctrl got wn=%0d wreg=%0b m2reg=%0b wmem=%0b ill=%0b exp wn=3 wreg=1", wn, wreg, m2reg, wmem, illegal); end

    @(negedge clk);
    inst = 32'h2024FFFF; rs_data = 32'd5; rt_data = 32'd0;
    tick();
    checks++; if (out_valid !== 1'b1 || aluc !== 4'b0000 || a_opd !== 32'd5 || b_opd !== 32'hFFFFFFFF || wn !== 5'd4 || wreg !== 1'b1) begin errors++; $display("FAIL addi_out got v=%0b aluc=%0h a=%0h b=%0h wn=%0d wreg=%0b exp 1/0/5/ffffffff/4/1", out_valid, aluc, a_opd, b_opd, wn, wreg); end

    @(negedge clk);
    inst = 32'h000228C0; rs_data = 32'hAAAA0000; rt_data = 32'h10;
    tick();
    checks++; if (aluc !== 4'b0011 || a_opd !== 32'd3 || b_opd !== 32'h10 || wn !== 5'd5 || wreg !== 1'b1) begin errors++; $display("FAIL sll_out got aluc=%0h a=%0h b=%0h wn=%0d wreg=%0b exp 3/3/10/5/1", aluc, a_opd, b_opd, wn, wreg); end

    @(negedge clk);
    inst = 32'h00021903; rt_data = 32'h80000000;
    tick();
    checks++; if (aluc !== 4'b1111 || a_opd !== 32'd4 || b_opd !== 32'h80000000 || wn !== 5'd3) begin errors++; $display("FAIL sra_out got aluc=%0h a=%0h b=%0h wn=%0d exp f/4/80000000/3", aluc, a_opd, b_opd, wn); end

    @(negedge clk);
    inst = 32'h342A8000; rs_data = 32'h11;
    tick();
    checks++; if (aluc !== 4'b0101 || a_opd !== 32'h11 || b_opd !== 32'h00008000 || wn !== 5'd10) begin errors++; $display("FAIL ori_out got aluc=%0h a=%0h b=%0h wn=%0d exp 5/11/8000/10", aluc, a_opd, b_opd, wn); end

    @(negedge clk);
    inst = 32'h3C091234; rs_data = 32'h0;
    tick();
    checks++; if (aluc !== 4'b0110 || b_opd !== 32'h00001234 || wn !== 5'd9 || wreg !== 1'b1) begin errors++; $display("FAIL lui_out got aluc=%0h b=%0h wn=%0d wreg=%0b exp 6/1234/9/1", aluc, b_opd, wn, wreg); end

    @(negedge clk);
    inst = 32'hAC220008; rs_data = 32'h100; rt_data = 32'hDEADBEEF;
    tick();
    checks++; if (aluc !== 4'b0000 || a_opd !== 32'h100 || b_opd !== 32'h8 || st_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_data got aluc=%0h a=%0h b=%0h st=%0h exp 0/100/8/deadbeef", aluc, a_opd, b_opd, st_data); end
    checks++; if (wmem !== 1'b1 || wreg !== 1'b0 || m2reg !== 1'b0) begin errors++; $display("FAIL sw_ctrl got wmem=%0b wreg=%0b m2reg=%0b exp 1/0/0", wmem, wreg, m2reg); end

    @(negedge clk);
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || wmem !== 1'b0 || wreg !== 1'b0) begin errors++; $display("FAIL drain got v=%0b wmem=%0b wreg=%0b exp 0/0/0", out_valid, wmem, wreg); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    inst = 32'h8C260000; rs_data = 32'h40; rt_data = 32'h0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || m2reg !== 1'b1 || wn !== 5'd6 || a_opd !== 32'h40 || b_opd !== 32'h0 || wreg !== 1'b1) begin errors++; $display("FAIL lw_out got v=%0b m2reg=%0b wn=%0d a=%0h b=%0h wreg=%0b exp 1/1/6/40/0/1", out_valid, m2reg, wn, a_opd, b_opd, wreg); end
    @(negedge clk);
    inst = 32'h00C63820; rs_data = 32'd3; rt_data = 32'd3;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL haz_in_ready got=%0b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || wreg !== 1'b0 || m2reg !== 1'b0) begin errors++; $display("FAIL haz_bubble got v=%0b wreg=%0b m2reg=%0b exp 0/0/0", out_valid, wreg, m2reg); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready got=%0b exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || aluc !== 4'b0000 || wn !== 5'd7 || a_opd !== 32'd3 || b_opd !== 32'd3 || wreg !== 1'b1) begin errors++; $display("FAIL dep_add got v=%0b aluc=%0h wn=%0d a=%0h b=%0h wreg=%0b exp 1/0/7/3/3/1", out_valid, aluc, wn, a_opd, b_opd, wreg); end
  endtask

  task automatic test_backpressure_flush();
    @(negedge clk);
    out_ready = 1'b0; inst = 32'h01095022; rs_data = 32'h77; rt_data = 32'h66;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got=%0b exp=0", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || wn !== 5'd7 || a_opd !== 32'd3 || b_opd !== 32'd3 || aluc !== 4'b0000 || wreg !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got v=%0b wn=%0d a=%0h b=%0h aluc=%0h wreg=%0b exp 1/7/3/3/0/1", i, out_valid, wn, a_opd, b_opd, aluc, wreg); end
      @(negedge clk);
    end
    flush = 1'b1; inst = 32'h01096026; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || wreg !== 1'b0) begin errors++; $display("FAIL flush_out got v=%0b wreg=%0b exp 0/0", out_valid, wreg); end
    checks++; if (wn === 5'd12) begin errors++; $display("FAIL flush_capture got wn=%0d exp not 12", wn); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || wreg !== 1'b0) begin errors++; $display("FAIL post_flush got v=%0b wreg=%0b exp 0/0", out_valid, wreg); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    inst = 32'h00221820; rs_data = 32'd5; rt_data = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b1; flush = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || wn !== 5'd0 || a_opd !== 32'h0 || b_opd !== 32'h0 || wreg !== 1'b0) begin errors++; $display("FAIL mid_reset got v=%0b wn=%0d a=%0h b=%0h wreg=%0b exp 0", out_valid, wn, a_opd, b_opd, wreg); end
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || wn !== 5'd3 || a_opd !== 32'd5) begin errors++; $display("FAIL after_reset_accept got v=%0b wn=%0d a=%0h exp 1/3/5", out_valid, wn, a_opd); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_illegal();
    @(negedge clk);
    inst = 32'hFC000000; rs_data = 32'h55; rt_data = 32'h66; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || wreg !== 1'b0 || wmem !== 1'b0 || m2reg !== 1'b0) begin errors++; $display("FAIL illegal_ctrl got v=%0b ill=%0b wreg=%0b wmem=%0b m2reg=%0b exp 1/1/0/0/0", out_valid, illegal, wreg, wmem, m2reg); end
    checks++; if (aluc !== 4'h0 || a_opd !== 32'h0 || b_opd !== 32'h0) begin errors++; $display("FAIL illegal_opd got aluc=%0h a=%0h b=%0h exp 0/0/0", aluc, a_opd, b_opd); end
    @(negedge clk);
    inst = 32'h10220003;
    tick();
    checks++; if (illegal !== 1'b1 || wreg !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL beq_illegal got ill=%0b wreg=%0b v=%0b exp 1/0/1", illegal, wreg, out_valid); end
    @(negedge clk);
    inst = 32'h0000002A; rt_data = 32'h1;
    tick();
    checks++; if (illegal !== 1'b1 || aluc !== 4'h0 || b_opd !== 32'h0) begin errors++; $display("FAIL rfunc_illegal got ill=%0b aluc=%0h b=%0h exp 1/0/0", illegal, aluc, b_opd); end
    @(negedge clk);
    inst = 32'h00200020; rs_data = 32'd1; rt_data = 32'd2;
    tick();
    checks++; if (wreg !== 1'b0 || out_valid !== 1'b1 || illegal !== 1'b0 || wn !== 5'd0) begin errors++; $display("FAIL add_r0 got wreg=%0b v=%0b ill=%0b wn=%0d exp 0/1/0/0", wreg, out_valid, illegal, wn); end
    @(negedge clk);
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inst = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
    test_reset();
    test_alu_ops();
    test_load_use();
    test_backpressure_flush();
    test_reset_midstream();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
